pc_trace_monitor: RTL and testbench

- Parametrised run monitor for the single-cycle MIPS core; replaces the ad-hoc 8-bit cycle counter and fixed-time stop in the core bench.
- Samples the core's PC every enabled cycle and counts cycles.
- Keeps a circular history of the last DEPTH distinct PCs.
- Detects a halt (PC stuck) or a cycle-budget timeout, then freezes so the bench or debug logic can read the trace.

---
 rtl/pc_trace_monitor.sv | 169 ++++++++++++++++
 tb/tb_pc_trace_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_monitor.sv
// Run monitor for the single-cycle MIPS core.
// Samples the core PC on enabled cycles and counts those cycles. It keeps a
// circular history of the most recent distinct PCs and freezes once the PC
// stops moving (HALT) or the cycle budget runs out (TIMEOUT), so the trace
// can be read back afterwards.
module pc_trace_monitor #(
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int MAX_CYCLES  = 64,
    parameter int STALL_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_WIDTH-1:0]        rd_pc,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic [1:0]                 state,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [CNT_WIDTH-1:0] CYCLE_LIMIT = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CYCLE_ONE   = CNT_WIDTH'(1);
    localparam logic [SW-1:0]        STALL_MAX   = SW'(STALL_LIMIT);
    localparam logic [SW-1:0]        STALL_ONE   = SW'(1);
    localparam logic [AW:0]          TRACE_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]          TRACE_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0]        PTR_ONE     = AW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALT    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    state_e                 state_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   cycleCount_q, cycleCount_d;
    logic [SW-1:0]          stallCount_q, stallCount_d;
    logic [AW:0]            traceCount_q, traceCount_d;
    logic [AW-1:0]          wrPtr_q, wrPtr_d;
    logic [PC_WIDTH-1:0]    lastPc_q, lastPc_d;
    logic [PC_WIDTH-1:0]    rdPc_q;
    logic [PC_WIDTH-1:0]    traceMem_q [DEPTH];

    logic                   sampleActive;
    logic                   wrEn;
    logic                   haltHit;
    logic                   timeoutHit;
    logic [AW-1:0]          rdAddr;
    logic                   rdValid;

    // Next values of the sampling datapath; only IDLE and RUN accept samples
    // and clear suppresses sampling entirely.
    always_comb begin
        cycleCount_d = cycleCount_q;
        stallCount_d = stallCount_q;
        traceCount_d = traceCount_q;
        wrPtr_d      = wrPtr_q;
        lastPc_d     = lastPc_q;
        wrEn         = 1'b0;
        sampleActive = enable && !clear && ((state_q == IDLE) || (state_q == RUN));

        if (sampleActive) begin
            if (state_q == IDLE) begin
                wrEn         = 1'b1;
                wrPtr_d      = wrPtr_q + PTR_ONE;
                traceCount_d = TRACE_ONE;
                lastPc_d     = pc;
                cycleCount_d = CYCLE_ONE;
                stallCount_d = '0;
            end else begin
                cycleCount_d = cycleCount_q + CYCLE_ONE;
                if (pc != lastPc_q) begin
                    wrEn         = 1'b1;
                    wrPtr_d      = wrPtr_q + PTR_ONE;
                    traceCount_d = (traceCount_q == TRACE_FULL) ? TRACE_FULL
                                                                : traceCount_q + TRACE_ONE;
                    lastPc_d     = pc;
                    stallCount_d = '0;
                end else begin
                    stallCount_d = stallCount_q + STALL_ONE;
                end
            end
        end

        haltHit    = sampleActive && (stallCount_d == STALL_MAX);
        timeoutHit = sampleActive && (cycleCount_d == CYCLE_LIMIT);
    end

    // Read address is taken relative to the pre-edge write pointer, so a read
    // coinciding with a write still sees the previous newest entry.
    always_comb begin
        rdAddr  = wrPtr_q - PTR_ONE - rd_idx;
        rdValid = ({1'b0, rd_idx} < traceCount_q);
    end

    // Trace storage has no reset; stale entries are masked by trace_count.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            traceMem_q[wrPtr_q] <= pc;
        end
    end

    // Control FSM with counters, registered done flag and registered read port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            cycleCount_q <= '0;
            stallCount_q <= '0;
            traceCount_q <= '0;
            wrPtr_q      <= '0;
            lastPc_q     <= '0;
            rdPc_q       <= '0;
        end else if (clear) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            cycleCount_q <= '0;
            stallCount_q <= '0;
            traceCount_q <= '0;
            wrPtr_q      <= '0;
            lastPc_q     <= '0;
            rdPc_q       <= '0;
        end else begin
            cycleCount_q <= cycleCount_d;
            stallCount_q <= stallCount_d;
            traceCount_q <= traceCount_d;
            wrPtr_q      <= wrPtr_d;
            lastPc_q     <= lastPc_d;
            rdPc_q       <= rdValid ? traceMem_q[rdAddr] : '0;

            case (state_q)
                IDLE, RUN: begin
                    if (sampleActive) begin
                        if (haltHit) begin
                            state_q <= HALT;
                            done_q  <= 1'b1;
                        end else if (timeoutHit) begin
                            state_q <= TIMEOUT;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    state_q <= state_q;
                    done_q  <= done_q;
                end
            endcase
        end
    end

    assign rd_pc       = rdPc_q;
    assign cycle_count = cycleCount_q;
    assign trace_count = traceCount_q;
    assign state       = state_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: three instances cover the default build, a
// short budget where halt and timeout coincide, and a small 4-entry trace.
module tb_pc_trace_monitor;

    logic clock;
    logic reset;

    // Default-parameter instance
    logic        clrA, enA;
    logic [31:0] pcA;
    logic [3:0]  idxA;
    logic [31:0] rdA;
    logic [7:0]  cycA;
    logic [4:0]  trcA;
    logic [1:0]  stA;
    logic        doneA;

    // MAX_CYCLES = 8 instance
    logic        clrB, enB;
    logic [31:0] pcB;
    logic [3:0]  idxB;
    logic [31:0] rdB;
    logic [7:0]  cycB;
    logic [4:0]  trcB;
    logic [1:0]  stB;
    logic        doneB;

    // DEPTH = 4, PC_WIDTH = 8 instance
    logic        clrC, enC;
    logic [7:0]  pcC;
    logic [1:0]  idxC;
    logic [7:0]  rdC;
    logic [7:0]  cycC;
    logic [2:0]  trcC;
    logic [1:0]  stC;
    logic        doneC;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        clr;
        logic [31:0] pc;
        logic [3:0]  idx;
        logic [1:0]  st;
        logic [7:0]  cyc;
        logic [4:0]  trc;
        logic        dn;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];
    int   pcsB[8] = '{0, 4, 8, 12, 12, 12, 12, 12};

    pc_trace_monitor dutA (
        .clock(clock), .reset(reset), .clear(clrA), .enable(enA), .pc(pcA),
        .rd_idx(idxA), .rd_pc(rdA), .cycle_count(cycA), .trace_count(trcA),
        .state(stA), .done(doneA)
    );

    pc_trace_monitor #(.MAX_CYCLES(8), .STALL_LIMIT(4)) dutB (
        .clock(clock), .reset(reset), .clear(clrB), .enable(enB), .pc(pcB),
        .rd_idx(idxB), .rd_pc(rdB), .cycle_count(cycB), .trace_count(trcB),
        .state(stB), .done(doneB)
    );

    pc_trace_monitor #(.DEPTH(4), .PC_WIDTH(8)) dutC (
        .clock(clock), .reset(reset), .clear(clrC), .enable(enC), .pc(pcC),
        .rd_idx(idxC), .rd_pc(rdC), .cycle_count(cycC), .trace_count(trcC),
        .state(stC), .done(doneC)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int tag,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, tag, actual, expected);
        end
    endtask

    task automatic addVec(input logic en, input logic clr, input logic [31:0] pc,
                          input logic [3:0] idx, input logic [1:0] st, input logic [7:0] cyc,
                          input logic [4:0] trc, input logic dn, input logic [31:0] rd);
        vec_t v;
        v.en = en; v.clr = clr; v.pc = pc; v.idx = idx;
        v.st = st; v.cyc = cyc; v.trc = trc; v.dn = dn; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        enA  = v.en;
        clrA = v.clr;
        pcA  = v.pc;
        idxA = v.idx;
        @(posedge clock);
        #1;
    endtask

    task automatic stepA(input logic en, input logic [31:0] pc, input logic [3:0] idx);
        enA  = en;
        pcA  = pc;
        idxA = idx;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clrA = 0; enA = 0; pcA = '0; idxA = '0;
        clrB = 0; enB = 0; pcB = '0; idxB = '0;
        clrC = 0; enC = 0; pcC = '0; idxC = '0;

        // Halt after four repeats of pc 8, reads of the frozen trace
        addVec(1, 0, 32'd0,   0, 1, 1, 1, 0, 32'd0);
        addVec(1, 0, 32'd4,   0, 1, 2, 2, 0, 32'd0);
        addVec(1, 0, 32'd8,   0, 1, 3, 3, 0, 32'd4);
        addVec(1, 0, 32'd8,   0, 1, 4, 3, 0, 32'd8);
        addVec(1, 0, 32'd8,   0, 1, 5, 3, 0, 32'd8);
        addVec(1, 0, 32'd8,   0, 1, 6, 3, 0, 32'd8);
        addVec(1, 0, 32'd8,   0, 2, 7, 3, 1, 32'd8);
        addVec(1, 0, 32'd100, 2, 2, 7, 3, 1, 32'd0);
        addVec(1, 0, 32'd104, 1, 2, 7, 3, 1, 32'd4);
        addVec(0, 0, 32'd0,   5, 2, 7, 3, 1, 32'd0);
        addVec(0, 0, 32'd0,   0, 2, 7, 3, 1, 32'd8);
        addVec(1, 1, 32'd50,  0, 0, 0, 0, 0, 32'd0);
        // Enable gaps: disabled-cycle pcs never reach the trace
        addVec(1, 0, 32'h10,  0, 1, 1, 1, 0, 32'h0);
        addVec(0, 0, 32'h20,  0, 1, 1, 1, 0, 32'h10);
        addVec(1, 0, 32'h30,  0, 1, 2, 2, 0, 32'h10);
        addVec(0, 0, 32'h40,  1, 1, 2, 2, 0, 32'h10);
        addVec(1, 0, 32'h50,  0, 1, 3, 3, 0, 32'h30);
        addVec(0, 0, 32'h60,  1, 1, 3, 3, 0, 32'h30);
        addVec(0, 0, 32'h60,  2, 1, 3, 3, 0, 32'h10);
        addVec(0, 0, 32'h60,  3, 1, 3, 3, 0, 32'h0);
        // Clear while running with enable high
        addVec(1, 1, 32'h70,  0, 0, 0, 0, 0, 32'h0);

        #3;
        checkOutput("reset_state", 0, 32'(stA), 32'd0);
        checkOutput("reset_cycle", 0, 32'(cycA), 32'd0);
        checkOutput("reset_trace", 0, 32'(trcA), 32'd0);
        checkOutput("reset_done", 0, 32'(doneA), 32'd0);
        checkOutput("reset_rdpc", 0, rdA, 32'd0);
        #9 reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("idle_hold_state", 0, 32'(stA), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("vec_state", i, 32'(stA), 32'(vecs[i].st));
            checkOutput("vec_cycle", i, 32'(cycA), 32'(vecs[i].cyc));
            checkOutput("vec_trace", i, 32'(trcA), 32'(vecs[i].trc));
            checkOutput("vec_done", i, 32'(doneA), 32'(vecs[i].dn));
            checkOutput("vec_rdpc", i, rdA, vecs[i].rd);
        end
        clrA = 1'b0;

        // Timeout: 64 distinct samples with the default budget
        for (int i = 0; i < 64; i++) begin
            stepA(1'b1, 32'(4 * i), 4'd0);
            if (i == 0) checkOutput("to_first_state", i, 32'(stA), 32'd1);
            if (i == 62) begin
                checkOutput("to_pre_state", i, 32'(stA), 32'd1);
                checkOutput("to_pre_cycle", i, 32'(cycA), 32'd63);
            end
        end
        checkOutput("to_state", 64, 32'(stA), 32'd3);
        checkOutput("to_cycle", 64, 32'(cycA), 32'd64);
        checkOutput("to_trace", 64, 32'(trcA), 32'd16);
        checkOutput("to_done", 64, 32'(doneA), 32'd1);
        stepA(1'b1, 32'd999, 4'd0);
        checkOutput("to_rd0", 65, rdA, 32'd252);
        checkOutput("to_frozen_cycle", 65, 32'(cycA), 32'd64);
        stepA(1'b1, 32'd999, 4'd15);
        checkOutput("to_rd15", 66, rdA, 32'd192);
        checkOutput("to_frozen_trace", 66, 32'(trcA), 32'd16);
        enA = 1'b0;

        // Halt and timeout on the same edge: halt wins
        for (int i = 0; i < 8; i++) begin
            enB = 1'b1;
            pcB = 32'(pcsB[i]);
            @(posedge clock);
            #1;
            if (i == 6) begin
                checkOutput("sim_pre_state", i, 32'(stB), 32'd1);
                checkOutput("sim_pre_cycle", i, 32'(cycB), 32'd7);
            end
        end
        checkOutput("sim_state", 8, 32'(stB), 32'd2);
        checkOutput("sim_cycle", 8, 32'(cycB), 32'd8);
        checkOutput("sim_trace", 8, 32'(trcB), 32'd4);
        checkOutput("sim_done", 8, 32'(doneB), 32'd1);
        enB = 1'b0;

        // Small trace wraps after four distinct pcs
        for (int i = 1; i <= 6; i++) begin
            enC = 1'b1;
            pcC = 8'(i);
            @(posedge clock);
            #1;
            if (i == 3) checkOutput("wrap_trace3", i, 32'(trcC), 32'd3);
        end
        checkOutput("wrap_trace", 6, 32'(trcC), 32'd4);
        checkOutput("wrap_cycle", 6, 32'(cycC), 32'd6);
        checkOutput("wrap_state", 6, 32'(stC), 32'd1);
        enC = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idxC = 2'(k);
            @(posedge clock);
            #1;
            checkOutput("wrap_rd", k, 32'(rdC), 32'(6 - k));
        end

        // Asynchronous reset lands between clock edges
        #2 reset = 1'b0;
        #1;
        checkOutput("async_state", 0, 32'(stA), 32'd0);
        checkOutput("async_cycle", 0, 32'(cycA), 32'd0);
        checkOutput("async_trace", 0, 32'(trcA), 32'd0);
        checkOutput("async_done", 0, 32'(doneA), 32'd0);
        checkOutput("async_rdpc", 0, rdA, 32'd0);
        checkOutput("async_stateB", 0, 32'(stB), 32'd0);
        checkOutput("async_traceC", 0, 32'(trcC), 32'd0);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
